// File: rtl/div_43x18.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
// Divide-by-zero completes in one cycle with an all-ones quotient and a flag.
module div_43x18 #(
  parameter int data_width_in1 = 43,
  parameter int data_width_in2 = 18
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic [data_width_in1-1:0] dividend,
  input  logic [data_width_in2-1:0] divisor,
  output logic                      busy,
  output logic                      done,
  output logic [data_width_in1-1:0] quotient,
  output logic [data_width_in2-1:0] remainder,
  output logic                      div_by_zero
);

  localparam int CNT_W = $clog2(data_width_in1 + 1);
  localparam int PR_W  = data_width_in2 + 1;
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(data_width_in1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [data_width_in2-1:0] divisor_q, divisor_d;
  logic [data_width_in1-1:0] shift_q, shift_d;
  logic [PR_W-1:0]           prem_q, prem_d;
  logic [data_width_in1-1:0] quot_q, quot_d;
  logic [data_width_in2-1:0] rem_q, rem_d;
  logic                      dbz_q, dbz_d;
  logic                      done_q, done_d;

  logic [PR_W:0]             shiftedWide;
  logic [PR_W:0]             trial;
  logic                      qBit;
  logic [PR_W-1:0]           nextPrem;
  logic [data_width_in1-1:0] nextShift;

  // The partial remainder never reaches 2^PR_W, so bit PR_W of the trial flags a borrow.
  always_comb begin
    shiftedWide = {prem_q, shift_q[data_width_in1-1]};
    trial       = shiftedWide - {2'b00, divisor_q};
    qBit        = ~trial[PR_W];
    nextPrem    = qBit ? trial[PR_W-1:0] : shiftedWide[PR_W-1:0];
    nextShift   = {shift_q[data_width_in1-2:0], qBit};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    shift_d   = shift_q;
    prem_d    = prem_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d   = RUN;
            divisor_d = divisor;
            shift_d   = dividend;
            prem_d    = '0;
            cnt_d     = ITERS;
          end else begin
            quot_d = '1;
            rem_d  = '0;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        shift_d = nextShift;
        prem_d  = nextPrem;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quot_d  = nextShift;
          rem_d   = nextPrem[data_width_in2-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      divisor_q <= '0;
      shift_q   <= '0;
      prem_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      shift_q   <= shift_d;
      prem_q    <= prem_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_43x18.sv
// Scoreboard bench for div_43x18: expected results queued at start, checked at done.
module tb_div_43x18;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [42:0] dividend;
  logic [17:0] divisor;
  logic        busy;
  logic        done;
  logic [42:0] quotient;
  logic [17:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [42:0] q;
    logic [17:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  div_43x18 dut (
    .CLK(CLK), .RST(RST), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [42:0] dd, input logic [17:0] dv, input bit push);
    exp_t e;
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    if (push) begin
      if (dv == 18'd0) begin
        e.q = '1;
        e.r = '0;
        e.z = 1'b1;
      end else begin
        e.q = dd / {25'd0, dv};
        e.r = 18'(dd % {25'd0, dv});
        e.z = 1'b0;
      end
      sb.push_back(e);
    end
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0d expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0d expected 0", done); end
    checks++; if (quotient !== 43'd0) begin errors++; $display("[TB] FAIL reset_quot: got %0d expected 0", quotient); end
    checks++; if (remainder !== 18'd0) begin errors++; $display("[TB] FAIL reset_rem: got %0d expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %0d expected 0", div_by_zero); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    int cyc;
    exp_t e;
    applyStimulus(43'd7000, 18'd7, 1'b1);
    waitDone(cyc);
    e = sb.pop_front();
    checks++; if (cyc != 43) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 43", cyc); end
    checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL basic_quot: got %0d expected %0d", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL basic_rem: got %0d expected %0d", remainder, e.r); end
    checks++; if (div_by_zero !== e.z) begin errors++; $display("[TB] FAIL basic_dbz: got %0d expected %0d", div_by_zero, e.z); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %0d expected 0", busy); end
    @(negedge CLK);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %0d expected 0", done); end
  endtask

  task automatic test_max_and_small();
    int cyc;
    exp_t e;
    applyStimulus(43'h7FF_FFFF_FFFF, 18'h3FFFF, 1'b1);
    waitDone(cyc);
    e = sb.pop_front();
    checks++; if (cyc != 43) begin errors++; $display("[TB] FAIL max_latency: got %0d expected 43", cyc); end
    checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL max_quot: got %0d expected %0d", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL max_rem: got %0d expected %0d", remainder, e.r); end
    @(negedge CLK);
    applyStimulus(43'd5, 18'd9, 1'b1);
    waitDone(cyc);
    e = sb.pop_front();
    checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL small_quot: got %0d expected %0d", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL small_rem: got %0d expected %0d", remainder, e.r); end
    @(negedge CLK);
  endtask

  task automatic test_div_zero();
    int cyc;
    exp_t e;
    applyStimulus(43'd12345, 18'd0, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL dbz_busy: got %0d expected 0", busy); end
    waitDone(cyc);
    e = sb.pop_front();
    checks++; if (cyc != 0) begin errors++; $display("[TB] FAIL dbz_latency: got %0d expected 0", cyc); end
    checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL dbz_quot: got %0h expected %0h", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL dbz_rem: got %0d expected %0d", remainder, e.r); end
    checks++; if (div_by_zero !== e.z) begin errors++; $display("[TB] FAIL dbz_flag: got %0d expected %0d", div_by_zero, e.z); end
    @(negedge CLK);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL dbz_after: got done=%0d busy=%0d expected 0 0", done, busy); end
    applyStimulus(43'd100, 18'd10, 1'b1);
    waitDone(cyc);
    e = sb.pop_front();
    checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL post_dbz_quot: got %0d expected %0d", quotient, e.q); end
    checks++; if (div_by_zero !== e.z) begin errors++; $display("[TB] FAIL post_dbz_flag: got %0d expected %0d", div_by_zero, e.z); end
    @(negedge CLK);
  endtask

  task automatic test_ignore_start();
    int doneCount = 0;
    int doneAt = 0;
    exp_t e;
    applyStimulus(43'd1000, 18'd3, 1'b1);
    for (int c = 1; c <= 60; c++) begin
      start = (c == 5 || c == 20);
      if (start) begin
        dividend = 43'd50;
        divisor  = 18'd5;
      end
      @(negedge CLK);
      if (done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) begin
          doneAt = c;
          e = sb.pop_front();
          checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL ignore_quot: got %0d expected %0d", quotient, e.q); end
          checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL ignore_rem: got %0d expected %0d", remainder, e.r); end
        end
      end
    end
    start = 1'b0;
    sb.delete();
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCount); end
    checks++; if (doneAt != 43) begin errors++; $display("[TB] FAIL ignore_done_cycle: got %0d expected 43", doneAt); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int doneCount = 0;
    exp_t e;
    applyStimulus(43'd1000, 18'd3, 1'b0);
    repeat (19) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %0d expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %0d expected 0", done); end
    checks++; if (quotient !== 43'd0) begin errors++; $display("[TB] FAIL midrst_quot: got %0d expected 0", quotient); end
    checks++; if (remainder !== 18'd0) begin errors++; $display("[TB] FAIL midrst_rem: got %0d expected 0", remainder); end
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (done === 1'b1) doneCount++;
    end
    checks++; if (doneCount != 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", doneCount); end
    applyStimulus(43'd81, 18'd9, 1'b1);
    waitDone(cyc);
    e = sb.pop_front();
    checks++; if (cyc != 43) begin errors++; $display("[TB] FAIL midrst_next_latency: got %0d expected 43", cyc); end
    checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL midrst_next_quot: got %0d expected %0d", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL midrst_next_rem: got %0d expected %0d", remainder, e.r); end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit holdOk;
    exp_t e;
    applyStimulus(43'd1000, 18'd3, 1'b1);
    waitDone(cyc);
    e = sb.pop_front();
    checks++; if (cyc != 43) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected 43", cyc); end
    checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("[TB] FAIL b2b_first: got %0d/%0d expected %0d/%0d", quotient, remainder, e.q, e.r); end
    applyStimulus(43'd81, 18'd9, 1'b1);
    holdOk = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (quotient !== e.q || remainder !== e.r) holdOk = 1'b0;
      @(negedge CLK);
      cyc++;
    end
    checks++; if (holdOk !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold: got %0d expected 1", holdOk); end
    e = sb.pop_front();
    checks++; if (cyc != 43) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 43", cyc); end
    checks++; if (quotient !== e.q) begin errors++; $display("[TB] FAIL b2b_second_quot: got %0d expected %0d", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("[TB] FAIL b2b_second_rem: got %0d expected %0d", remainder, e.r); end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_max_and_small();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
